seg7_2421_scan_driver: RTL

SEG7_2421_SCAN_DRIVER -- requirements
Module: seg7_2421_scan_driver

---
 rtl/seg7_2421_pkg.sv | 43 ++++
 rtl/seg7_2421_scan_driver_code2421_to_bcd.sv | 26 ++
 rtl/seg7_2421_scan_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_2421_pkg.sv
// Shared constants for the 2421 scan driver: segment patterns and 2421 code ranges.
package seg7_2421_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Valid 2421 codes are 0000..0100 (0-4) and 1011..1111 (5-9)
  localparam logic [3:0] CODE_LOW_MAX     = 4'b0100;
  localparam logic [3:0] CODE_HIGH_MIN    = 4'b1011;
  localparam logic [3:0] CODE_HIGH_OFFSET = 4'd6;
  localparam logic [3:0] CODE_ZERO        = 4'b0000;
  localparam logic [3:0] BCD_INVALID      = 4'hF;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_2421_scan_driver_code2421_to_bcd.sv
// Combinational 2421 -> 8421 BCD converter; invalid codes yield 4'hF with valid=0.
module code2421_to_bcd
  import seg7_2421_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       valid
);

  // Low half maps straight through, high half is offset by six
  always_comb begin
    bcd   = BCD_INVALID;
    valid = 1'b0;
    if (code <= CODE_LOW_MAX) begin
      bcd   = code;
      valid = 1'b1;
    end else if (code >= CODE_HIGH_MIN) begin
      bcd   = code - CODE_HIGH_OFFSET;
      valid = 1'b1;
    end else begin
      bcd   = BCD_INVALID;
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_2421_scan_driver.sv
// Multiplexed 7-segment driver for 2421-coded digits, with BCD readback and a
// sticky invalid-code flag.
module seg7_2421_scan_driver
  import seg7_2421_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  blank_lz,
  input  logic                  err_clr,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] digit_q, digit_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                bcd_valid_q, bcd_valid_d;
  logic                err_q, err_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [4*DIGITS-1:0] din_bcd_s;
  logic [DIGITS-1:0]   din_valid_s;
  logic [3:0]          scan_code_s;
  logic [3:0]          scan_bcd_s;
  logic                scan_valid_s;
  logic [DIGITS-1:0]   lz_s;
  logic                above_zero_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_din_conv
    code2421_to_bcd u_conv (
      .code  (din[4*g +: 4]),
      .bcd   (din_bcd_s[4*g +: 4]),
      .valid (din_valid_s[g])
    );
  end

  assign scan_code_s = digit_q[{idx_q, 2'b00} +: 4];

  code2421_to_bcd u_scan_conv (
    .code  (scan_code_s),
    .bcd   (scan_bcd_s),
    .valid (scan_valid_s)
  );

  // lz_s[i] is set when digit i and every digit above it hold code zero
  always_comb begin
    lz_s         = '0;
    above_zero_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      above_zero_s = above_zero_s & (digit_q[4*i +: 4] == CODE_ZERO);
      lz_s[i]      = above_zero_s;
    end
  end

  always_comb begin
    digit_d     = digit_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    if (load) begin
      digit_d     = din;
      bcd_d       = din_bcd_s;
      bcd_valid_d = 1'b1;
    end else begin
      bcd_valid_d = 1'b0;
    end

    // A new invalid load wins over a simultaneous clear
    if (load && !(&din_valid_s)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end

    if (!scan_valid_s) begin
      seg_d = SEG_DASH;
    end else if (blank_lz && lz_s[idx_q]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = bcd_to_seg(scan_bcd_s);
    end
    an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q     <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      digit_q     <= digit_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      err_q       <= err_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign err       = err_q;

endmodule
